poly_rng_feeder: RTL and testbench

POLY_RNG_FEEDER -- requirements
Module: poly_rng_feeder

---
 rtl/poly_pkg.sv | 15 +
 rtl/poly_rng_feeder_fifo.sv | 64 ++++++
 rtl/poly_rng_feeder.sv | 78 +++++++
 tb/tb_poly_rng_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared widths and helpers for the polynomial RNG feeder.
package poly_pkg;

    localparam int RNG_W     = 128;
    localparam int BEAT_W    = 64;
    localparam int DEF_DEPTH = 4;

    // Width of a 0..depth occupancy counter.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W_DEF = lvl_w(DEF_DEPTH);

endpackage

// File: rtl/poly_rng_feeder_fifo.sv
// Synchronous FIFO of 128-bit random words; storage itself is not reset.
module rng_fifo
    import poly_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [RNG_W-1:0]         wdata,
    output logic [RNG_W-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [RNG_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Word storage write; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

    // Head word, forced to zero while nothing is stored.
    always_comb begin
        rdata = {RNG_W{1'b0}};
        if (!empty) rdata = mem_r[rd_ptr_r];
        else        rdata = {RNG_W{1'b0}};
    end

endmodule

// File: rtl/poly_rng_feeder.sv
// Packs pairs of 64-bit XOF beats into 128-bit random words and buffers them.
module poly_rng_feeder #(
    parameter int DEPTH  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      in_valid,
    input  logic [BEAT_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      rng_valid,
    output logic [2*BEAT_W-1:0]       rng,
    input  logic                      rng_extract,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      err_underflow
);

    import poly_pkg::*;

    logic [BEAT_W-1:0] low_r;
    logic              half_r;
    logic              err_r;
    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    // Ready depends only on stored state and enable, never on in_valid.
    assign in_ready      = ena && !full_s;
    assign accept_s      = in_valid && in_ready;
    assign push_s        = accept_s && half_r;
    assign pop_s         = ena && rng_extract && !empty_s;
    assign rng_valid     = !empty_s;
    assign err_underflow = err_r;

    // Beat packer: first beat parked as the low half, second beat completes the word.
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            low_r  <= {BEAT_W{1'b0}};
            half_r <= 1'b0;
        end else if (accept_s) begin
            low_r  <= half_r ? low_r : in_data;
            half_r <= !half_r;
        end else begin
            low_r  <= low_r;
            half_r <= half_r;
        end
    end

    // Sticky underflow flag; cleared only by reset or by dropping enable.
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            err_r <= 1'b0;
        end else if (rng_extract && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    rng_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!ena),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({in_data, low_r}),
        .rdata (rng),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

endmodule

// File: tb/tb_poly_rng_feeder.sv
// Directed and scoreboard-checked bench for poly_rng_feeder (DEPTH=4).
module tb_poly_rng_feeder;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_ready;
    logic         rng_valid;
    logic [127:0] rng;
    logic         rng_extract;
    logic [2:0]   level;
    logic         err_underflow;

    int checks   = 0;
    int failures = 0;

    poly_rng_feeder #(.DEPTH(4), .BEAT_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rng_valid     (rng_valid),
        .rng           (rng),
        .rng_extract   (rng_extract),
        .level         (level),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ena;
        logic         vld;
        logic [63:0]  data;
        logic         ext;
        logic         e_ready;
        logic         e_valid;
        logic [127:0] e_rng;
        logic [2:0]   e_level;
        logic         e_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input logic [63:0] d, input logic x);
        ena = e; in_valid = v; in_data = d; rng_extract = x;
    endtask

    localparam logic [63:0] B11 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] A0  = 64'hA0A0_0000_0000_00A0;
    localparam logic [63:0] A1  = 64'hA1A1_0000_0000_00A1;
    localparam logic [63:0] C0  = 64'hB0B0_0000_0000_00B0;
    localparam logic [63:0] C1  = 64'hB1B1_0000_0000_00B1;
    localparam logic [63:0] D0  = 64'hC0C0_0000_0000_00C0;

    logic [127:0] exp_q [$];
    logic [63:0]  low_m;
    logic         half_m;
    logic         ready_m;
    int           beats;
    int           popped;
    int           cyc;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        step();
        chk("reset_level", {125'h0, level}, 128'h0);
        chk("reset_valid", {127'h0, rng_valid}, 128'h0);
        chk("reset_rng", rng, 128'h0);
        chk("reset_err", {127'h0, err_underflow}, 128'h0);
        chk("reset_ready", {127'h0, in_ready}, 128'h0);
        rst_n = 1'b1;

        // ena vld data ext | ready valid rng level err
        vecs[0]  = '{1'b1, 1'b1, B11,   1'b0, 1'b1, 1'b0, 128'h0,      3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, B22,   1'b0, 1'b1, 1'b1, {B22, B11},  3'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, A0,    1'b0, 1'b1, 1'b1, {B22, B11},  3'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, A1,    1'b0, 1'b1, 1'b1, {B22, B11},  3'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, C0,    1'b0, 1'b1, 1'b1, {B22, B11},  3'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, C1,    1'b1, 1'b1, 1'b1, {A1, A0},    3'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, {C1, C0},    3'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 128'h0,      3'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 128'h0,      3'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 128'h0,      3'd0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, D0,    1'b1, 1'b0, 1'b0, 128'h0,      3'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, D0,    1'b0, 1'b1, 1'b0, 128'h0,      3'd0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ena, vecs[i].vld, vecs[i].data, vecs[i].ext);
            step();
            chk($sformatf("vec%0d_ready", i), {127'h0, in_ready}, {127'h0, vecs[i].e_ready});
            chk($sformatf("vec%0d_valid", i), {127'h0, rng_valid}, {127'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_rng", i), rng, vecs[i].e_rng);
            chk($sformatf("vec%0d_level", i), {125'h0, level}, {125'h0, vecs[i].e_level});
            chk($sformatf("vec%0d_err", i), {127'h0, err_underflow}, {127'h0, vecs[i].e_err});
        end

        // Fill to full: 8 beats, then a 9th offered beat must be refused.
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 64'h100 + 64'(i), 1'b0);
            step();
        end
        chk("full_level", {125'h0, level}, 128'd4);
        chk("full_ready", {127'h0, in_ready}, 128'h0);
        drive(1'b1, 1'b1, 64'hDEAD, 1'b0);
        step();
        chk("full_9th_level", {125'h0, level}, 128'd4);
        chk("full_head", rng, {64'h101, 64'h100});
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        step();
        chk("full_pop_level", {125'h0, level}, 128'd3);
        chk("full_pop_head", rng, {64'h103, 64'h102});
        drive(1'b1, 1'b1, 64'hE0, 1'b0);
        step();
        drive(1'b1, 1'b1, 64'hE1, 1'b0);
        step();
        chk("refill_level", {125'h0, level}, 128'd4);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("refill_tail", rng, {64'hE1, 64'hE0});
        chk("refill_tail_level", {125'h0, level}, 128'd1);

        // Reset mid-operation discards a parked half beat and the sticky error.
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        step();
        step();
        chk("pre_rst_err", {127'h0, err_underflow}, 128'h1);
        drive(1'b1, 1'b1, 64'hF0F0, 1'b0);
        step();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 64'h5555, 1'b0);
        step();
        chk("rst_mid_level", {125'h0, level}, 128'h0);
        chk("rst_mid_valid", {127'h0, rng_valid}, 128'h0);
        chk("rst_mid_err", {127'h0, err_underflow}, 128'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 64'h6060, 1'b0);
        step();
        chk("rst_half_level", {125'h0, level}, 128'h0);
        drive(1'b1, 1'b1, 64'h6161, 1'b0);
        step();
        chk("rst_word", rng, {64'h6161, 64'h6060});
        chk("rst_word_level", {125'h0, level}, 128'd1);

        // Random stream of 40 words against a queue model.
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        step();
        half_m = 1'b0; low_m = 64'h0; beats = 0; popped = 0; cyc = 0;
        exp_q.delete();
        while (popped < 40 && cyc < 4000) begin
            ena = 1'b1;
            in_valid = (beats < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data = {32'hC0DE_0000, 32'(beats)};
            rng_extract = 1'($urandom_range(0, 1));
            #1;
            ready_m = (exp_q.size() < 4);
            chk("stream_ready", {127'h0, in_ready}, {127'h0, ready_m});
            chk("stream_level", {125'h0, level}, 128'(exp_q.size()));
            if (rng_extract && exp_q.size() > 0) begin
                chk("stream_word", rng, exp_q[0]);
                void'(exp_q.pop_front());
                popped++;
            end
            if (in_valid && ready_m) begin
                if (half_m) exp_q.push_back({in_data, low_m});
                else        low_m = in_data;
                half_m = !half_m;
                beats++;
            end
            step();
            cyc++;
        end
        chk("stream_popped", 128'(popped), 128'd40);
        chk("stream_wraps_ge10", 128'(popped / 4 >= 10), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
